// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / debug) arbiter in front of a single-port data memory.
// Optional macro DMEM_ARB_RR_EN selects round-robin on contention; default build gives CPU priority.
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk_pi,
  input  logic              reset_n_pi,
  input  logic              clk_en_pi,

  input  logic              cpu_req_pi,
  input  logic              cpu_write_pi,
  input  logic [ADDR_W-1:0] cpu_addr_pi,
  input  logic [DATA_W-1:0] cpu_wdata_pi,
  output logic              cpu_ack_po,
  output logic [DATA_W-1:0] cpu_rdata_po,
  output logic              cpu_stall_po,

  input  logic              dbg_req_pi,
  input  logic              dbg_write_pi,
  input  logic [ADDR_W-1:0] dbg_addr_pi,
  input  logic [DATA_W-1:0] dbg_wdata_pi,
  output logic              dbg_ack_po,
  output logic [DATA_W-1:0] dbg_rdata_po,

  output logic              mem_write_po,
  output logic [ADDR_W-1:0] mem_addr_po,
  output logic [DATA_W-1:0] mem_wdata_po,
  input  logic [DATA_W-1:0] mem_rdata_pi
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SRV_CPU  = 3'd1,
    SRV_DBG  = 3'd2,
    DONE_CPU = 3'd3,
    DONE_DBG = 3'd4
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DBG = 1'b1;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              last_grant_nxt;
  logic              any_req;
  logic              grant_dbg;
  logic              accept;
  logic              in_srv;

  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] dbg_rdata;

  // Debug wins only when it is the sole requester, or (round-robin) when CPU had the last turn.
  always_comb begin
    any_req   = cpu_req_pi | dbg_req_pi;
`ifdef DMEM_ARB_RR_EN
    grant_dbg = dbg_req_pi & (~cpu_req_pi | (last_grant == GRANT_CPU));
`else
    grant_dbg = dbg_req_pi & ~cpu_req_pi;
`endif
  end

  always_ff @(posedge clk_pi) begin
    if (!reset_n_pi) begin
      state <= IDLE;
    end else if (clk_en_pi) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          accept         = 1'b1;
          state_nxt      = grant_dbg ? SRV_DBG : SRV_CPU;
          last_grant_nxt = grant_dbg ? GRANT_DBG : GRANT_CPU;
        end
      end
      SRV_CPU:  state_nxt = DONE_CPU;
      SRV_DBG:  state_nxt = DONE_DBG;
      DONE_CPU: state_nxt = IDLE;
      DONE_DBG: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (!reset_n_pi) begin
      last_grant <= GRANT_DBG;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else if (clk_en_pi) begin
      last_grant <= last_grant_nxt;
      if (accept) begin
        req_write <= grant_dbg ? dbg_write_pi : cpu_write_pi;
        req_addr  <= grant_dbg ? dbg_addr_pi  : cpu_addr_pi;
        req_wdata <= grant_dbg ? dbg_wdata_pi : cpu_wdata_pi;
      end
      if (state == SRV_CPU && !req_write) begin
        cpu_rdata <= mem_rdata_pi;
      end
      if (state == SRV_DBG && !req_write) begin
        dbg_rdata <= mem_rdata_pi;
      end
    end
  end

  // The write strobe is qualified so a frozen or resetting cycle never commits a store.
  always_comb begin
    in_srv       = (state == SRV_CPU) || (state == SRV_DBG);
    mem_write_po = in_srv & req_write & clk_en_pi & reset_n_pi;
    mem_addr_po  = in_srv ? req_addr  : '0;
    mem_wdata_po = in_srv ? req_wdata : '0;
    cpu_ack_po   = (state == DONE_CPU);
    dbg_ack_po   = (state == DONE_DBG);
    cpu_stall_po = cpu_req_pi & ~cpu_ack_po;
    cpu_rdata_po = cpu_rdata;
    dbg_rdata_po = dbg_rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test of dmem_arbiter against a small behavioural memory.
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_en;
  logic          cpu_req, cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_write;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:255];
  logic          init_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_pi       (clk),
    .reset_n_pi   (reset_n),
    .clk_en_pi    (clk_en),
    .cpu_req_pi   (cpu_req),
    .cpu_write_pi (cpu_write),
    .cpu_addr_pi  (cpu_addr),
    .cpu_wdata_pi (cpu_wdata),
    .cpu_ack_po   (cpu_ack),
    .cpu_rdata_po (cpu_rdata),
    .cpu_stall_po (cpu_stall),
    .dbg_req_pi   (dbg_req),
    .dbg_write_pi (dbg_write),
    .dbg_addr_pi  (dbg_addr),
    .dbg_wdata_pi (dbg_wdata),
    .dbg_ack_po   (dbg_ack),
    .dbg_rdata_po (dbg_rdata),
    .mem_write_po (mem_write),
    .mem_addr_po  (mem_addr),
    .mem_wdata_po (mem_wdata),
    .mem_rdata_pi (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[1] <= 16'h1111;
      mem[2] <= 16'h2222;
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clk_en  = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic exp_dbg;
  logic dbg_served;

  initial begin
    init_mem  = 1'b1;
    reset_n   = 1'b0;
    clk_en    = 1'b1;
    cpu_req   = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req   = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick();
    init_mem  = 1'b0;
    tick();
    check("rst_cpu_ack",   {31'b0, cpu_ack},   32'h0);
    check("rst_dbg_ack",   {31'b0, dbg_ack},   32'h0);
    check("rst_cpu_rdata", {16'b0, cpu_rdata}, 32'h0);
    check("rst_dbg_rdata", {16'b0, dbg_rdata}, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_mem_addr",  {16'b0, mem_addr},  32'h0);
    check("rst_stall",     {31'b0, cpu_stall}, 32'h0);
    reset_n = 1'b1;

    // CPU store 0x0010 <- 0xBEEF then load back
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    #1;
    check("st_n_stall",  {31'b0, cpu_stall}, 32'h1);
    check("st_n_wr",     {31'b0, mem_write}, 32'h0);
    tick();
    check("st_n1_wr",    {31'b0, mem_write}, 32'h1);
    check("st_n1_addr",  {16'b0, mem_addr},  32'h0010);
    check("st_n1_wdata", {16'b0, mem_wdata}, 32'hBEEF);
    check("st_n1_stall", {31'b0, cpu_stall}, 32'h1);
    check("st_n1_ack",   {31'b0, cpu_ack},   32'h0);
    tick();
    check("st_n2_ack",   {31'b0, cpu_ack},   32'h1);
    check("st_n2_stall", {31'b0, cpu_stall}, 32'h0);
    check("st_n2_wr",    {31'b0, mem_write}, 32'h0);
    check("st_n2_addr",  {16'b0, mem_addr},  32'h0);
    cpu_req = 1'b0; cpu_write = 1'b0;
    tick();
    check("st_n3_ack",   {31'b0, cpu_ack},   32'h0);
    check("st_mem",      {16'b0, mem[16]},   32'hBEEF);
    check("st_rdata",    {16'b0, cpu_rdata}, 32'h0);
    cpu_req = 1'b1;
    tick();
    check("ld_n1_wr",    {31'b0, mem_write}, 32'h0);
    check("ld_n1_addr",  {16'b0, mem_addr},  32'h0010);
    tick();
    check("ld_n2_ack",   {31'b0, cpu_ack},   32'h1);
    check("ld_n2_rdata", {16'b0, cpu_rdata}, 32'hBEEF);
    cpu_req = 1'b0;
    tick();
    check("ld_n3_ack",   {31'b0, cpu_ack},   32'h0);
    check("ld_hold",     {16'b0, cpu_rdata}, 32'hBEEF);

    // reset asserted while a CPU store to 0x0005 is in SRV_CPU
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'h5555;
    tick();
    check("ra_srv_wr",   {31'b0, mem_write}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("ra_rst_wr",   {31'b0, mem_write}, 32'h0);
    cpu_req = 1'b0; cpu_write = 1'b0;
    tick();
    check("ra_ack",      {31'b0, cpu_ack},   32'h0);
    check("ra_addr",     {16'b0, mem_addr},  32'h0);
    check("ra_cpu_rd",   {16'b0, cpu_rdata}, 32'h0);
    check("ra_dbg_rd",   {16'b0, dbg_rdata}, 32'h0);
    check("ra_mem",      {16'b0, mem[5]},    32'h0);
    reset_n = 1'b1;
    tick();
    check("ra_ack2",     {31'b0, cpu_ack},   32'h0);

    // both ports hold load requests from reset
    do_reset();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0001;
    dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 16'h0002;
    dbg_served = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
      exp_dbg = (k % 2) == 1;
`else
      exp_dbg = 1'b0;
`endif
      tick();
      check("arb_addr",  {16'b0, mem_addr}, exp_dbg ? 32'h0002 : 32'h0001);
      tick();
      if (exp_dbg) dbg_served = 1'b1;
      check("arb_cpu_ack", {31'b0, cpu_ack}, {31'b0, ~exp_dbg});
      check("arb_dbg_ack", {31'b0, dbg_ack}, {31'b0, exp_dbg});
      check("arb_cpu_rd",  {16'b0, cpu_rdata}, 32'h1111);
      check("arb_dbg_rd",  {16'b0, dbg_rdata}, dbg_served ? 32'h2222 : 32'h0);
      tick();
    end
    cpu_req = 1'b0;
    tick();
    check("solo_dbg_addr", {16'b0, mem_addr}, 32'h0002);
    tick();
    check("solo_dbg_ack",  {31'b0, dbg_ack},   32'h1);
    check("solo_dbg_rd",   {16'b0, dbg_rdata}, 32'h2222);
    dbg_req = 1'b0;
    tick();

    // clock enable low for 3 cycles while a debug store sits in SRV_DBG
    do_reset();
    dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 16'h0020; dbg_wdata = 16'hA5A5;
    tick();
    check("fz_srv_wr",   {31'b0, mem_write}, 32'h1);
    check("fz_srv_addr", {16'b0, mem_addr},  32'h0020);
    dbg_req = 1'b0; clk_en = 1'b0;
    #1;
    check("fz_off_wr",   {31'b0, mem_write}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fz_wr",   {31'b0, mem_write}, 32'h0);
      check("fz_ack",  {31'b0, dbg_ack},   32'h0);
      check("fz_addr", {16'b0, mem_addr},  32'h0020);
      check("fz_mem",  {16'b0, mem[32]},   32'h0);
    end
    clk_en = 1'b1;
    #1;
    check("fz_on_wr",    {31'b0, mem_write}, 32'h1);
    tick();
    check("fz_done_ack", {31'b0, dbg_ack},   32'h1);
    tick();
    check("fz_idle_ack", {31'b0, dbg_ack},   32'h0);
    check("fz_mem_done", {16'b0, mem[32]},   32'hA5A5);
    check("fz_st_rd",    {16'b0, dbg_rdata}, 32'h0);
    dbg_req = 1'b1; dbg_write = 1'b0;
    tick();
    tick();
    check("fz_ld_ack",   {31'b0, dbg_ack},   32'h1);
    check("fz_ld_rd",    {16'b0, dbg_rdata}, 32'hA5A5);
    dbg_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
